// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Input-side front end for the whack-a-mole game. Raw pushbutton inputs are
// synchronised and debounced, and single-cycle press events are produced for
// the game core's hit/miss logic.
//
// Ports:
//   clk          in   1      system clock (1 MHz nominal)
//   rst_n        in   1      synchronous reset, active-low
//   btn_raw      in   N_BTN  raw asynchronous button inputs, active-high
//   enable       in   1      1 = game running, 0 = press events suppressed
//   btn_level    out  N_BTN  debounced button levels
//   btn_press    out  N_BTN  one-cycle pulse per bit on a debounced 0->1
//   press_valid  out  1      one-cycle pulse when exactly one press edge occurs
//   press_idx    out  IDX_W  index of that button while press_valid=1, else 0
//   multi_press  out  1      one-cycle pulse when more than one press edge occurs
//
// Configuration macro:
//   BTN_LOCKOUT_EN  when defined, any emitted event closes the event gate until
//                   every debounced level has returned to 0. This blocks
//                   "roll" presses across buttons. When undefined, each button
//                   is gated only by its own debounced release.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10,
  parameter int IDX_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             press_valid,
  output logic [IDX_W-1:0] press_idx,
  output logic             multi_press
);

  // Terminal count: once the counter sits here and the input still disagrees
  // with the accepted level, the input has been stable for DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser, kept free of any logic between the stages.
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  // Per-button debounce counters and accepted levels.
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_d;
  logic [N_BTN-1:0]            level_q;
  logic [N_BTN-1:0]            level_d;
  logic [N_BTN-1:0]            rise;

  // Registered event outputs and their next-state values.
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;
  logic             valid_q;
  logic             valid_d;
  logic             multi_q;
  logic             multi_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Event decode helpers. IDX_W+1 bits always hold a count up to N_BTN.
  logic [IDX_W:0]   press_cnt;
  logic [IDX_W-1:0] first_idx;
  logic             gate_open;

`ifdef BTN_LOCKOUT_EN
  logic lock_q;
  logic lock_d;
`endif

  // Debounce: the counter measures how long the synchronised input has
  // disagreed with the accepted level. Any agreement restarts it from zero,
  // so a glitch shorter than DEBOUNCE_CYCLES never reaches the terminal count.
  // The counter is cleared on acceptance, so it can never wrap.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        rise[i]    = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // The event gate follows enable; with lockout built in it is also held
  // closed while a previous event's buttons have not all been released.
`ifdef BTN_LOCKOUT_EN
  assign gate_open = enable & ~lock_q;
`else
  assign gate_open = enable;
`endif

  // Press events are taken from the same edge that updates btn_level, so a
  // level that rose while the gate was closed never produces a late event.
  always_comb begin
    press_d   = rise & {N_BTN{gate_open}};
    press_cnt = '0;
    first_idx = '0;
    for (int i = 0; i < N_BTN; i++) begin
      press_cnt = press_cnt + (IDX_W+1)'(press_d[i]);
      if (press_d[i]) begin
        first_idx = IDX_W'(i);
      end
    end
    valid_d = (press_cnt == (IDX_W+1)'(1));
    multi_d = (press_cnt >  (IDX_W+1)'(1));
    idx_d   = valid_d ? first_idx : '0;
  end

`ifdef BTN_LOCKOUT_EN
  // Setting wins over clearing: a fresh event on the edge where all previous
  // levels read 0 must still lock out whatever follows it.
  always_comb begin
    lock_d = lock_q;
    if (valid_d || multi_d) begin
      lock_d = 1'b1;
    end else if (level_q == '0) begin
      lock_d = 1'b0;
    end
  end
`endif

  // All state, including a mid-debounce count, is discarded by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      press_q <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      idx_q   <= '0;
`ifdef BTN_LOCKOUT_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      idx_q   <= idx_d;
`ifdef BTN_LOCKOUT_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign press_valid = valid_q;
  assign press_idx   = idx_q;
  assign multi_press = multi_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4. A
// behavioural model derives the expected outputs every cycle: a button's
// level flips when the last DEBOUNCE_CYCLES synchronised samples all differ
// from it, and events are decoded from the gated rising flips. Directed
// scenarios add literal expectations, followed by a randomised run.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int NBtn   = 8;
  localparam int Db     = 4;
  localparam int CntW   = 3;
  localparam int IdxW   = 3;

  logic            clk;
  logic            rst_n;
  logic [NBtn-1:0] btn_raw;
  logic            enable;
  logic [NBtn-1:0] btn_level;
  logic [NBtn-1:0] btn_press;
  logic            press_valid;
  logic [IdxW-1:0] press_idx;
  logic            multi_press;

  int testsRun    = 0;
  int testsFailed = 0;
  int pressCount  = 0;
  bit checkEn     = 0;

  button_conditioner #(
    .N_BTN          (NBtn),
    .DEBOUNCE_CYCLES(Db),
    .CNT_W          (CntW),
    .IDX_W          (IdxW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .enable     (enable),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .press_valid(press_valid),
    .press_idx  (press_idx),
    .multi_press(multi_press)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any disagreement.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model. rawQ delays the raw bus by two edges to give the
  // synchronised value; s2Win holds the last Db synchronised samples.
  // ------------------------------------------------------------------------
  logic [NBtn-1:0] rawQ[$];
  logic [NBtn-1:0] s2Win[$];
  logic [NBtn-1:0] mLevel;
  logic [NBtn-1:0] mNewLevel;
  logic [NBtn-1:0] mRise;
  logic [NBtn-1:0] s2Now;
  logic [NBtn-1:0] expLevel;
  logic [NBtn-1:0] expPress;
  logic            expValid;
  logic            expMulti;
  logic [IdxW-1:0] expIdx;
  bit              mLock;
  bit              mGate;
  bit              allDiffer;
  int              nPress;

  always @(posedge clk) begin
    if (!rst_n) begin
      rawQ.delete();
      rawQ.push_back('0);
      rawQ.push_back('0);
      s2Win.delete();
      for (int j = 0; j < Db; j++) s2Win.push_back('0);
      mLevel   = '0;
      expPress = '0;
      expValid = 1'b0;
      expMulti = 1'b0;
      expIdx   = '0;
      mLock    = 1'b0;
    end else begin
      s2Now = rawQ.pop_front();
      rawQ.push_back(btn_raw);
      void'(s2Win.pop_front());
      s2Win.push_back(s2Now);
      mNewLevel = mLevel;
      mRise     = '0;
      for (int i = 0; i < NBtn; i++) begin
        allDiffer = 1'b1;
        foreach (s2Win[j]) if (s2Win[j][i] == mLevel[i]) allDiffer = 1'b0;
        if (allDiffer) begin
          mNewLevel[i] = ~mLevel[i];
          mRise[i]     = ~mLevel[i];
        end
      end
      mGate = enable;
`ifdef BTN_LOCKOUT_EN
      mGate = mGate && !mLock;
`endif
      expPress = mGate ? mRise : '0;
      nPress   = $countones(expPress);
      expValid = (nPress == 1);
      expMulti = (nPress > 1);
      expIdx   = '0;
      if (nPress == 1) begin
        for (int i = 0; i < NBtn; i++) if (expPress[i]) expIdx = IdxW'(i);
      end
`ifdef BTN_LOCKOUT_EN
      if (expValid || expMulti) mLock = 1'b1;
      else if (mLevel == '0)    mLock = 1'b0;
`endif
      mLevel = mNewLevel;
    end
    expLevel = mLevel;
  end

  // Every-cycle comparison against the model, sampled 1 unit after the edge.
  always @(posedge clk) begin
    #1;
    if (checkEn) begin
      checkOutput("btn_level",   32'(btn_level),   32'(expLevel));
      checkOutput("btn_press",   32'(btn_press),   32'(expPress));
      checkOutput("press_valid", 32'(press_valid), 32'(expValid));
      checkOutput("press_idx",   32'(press_idx),   32'(expIdx));
      checkOutput("multi_press", 32'(multi_press), 32'(expMulti));
      if (btn_press != '0) pressCount++;
    end
  end

  // Advance n rising edges and settle just after the last one.
  task automatic waitSample(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive new inputs on a falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic [NBtn-1:0] raw, input logic en);
    @(negedge clk);
    btn_raw = raw;
    enable  = en;
  endtask

  // Checks the event outputs against literal values.
  task automatic checkEvent(input string tag, input logic [NBtn-1:0] press,
                            input logic valid, input logic [IdxW-1:0] idx,
                            input logic multi);
    checkOutput({tag, ".press"}, 32'(btn_press),   32'(press));
    checkOutput({tag, ".valid"}, 32'(press_valid), 32'(valid));
    checkOutput({tag, ".idx"},   32'(press_idx),   32'(idx));
    checkOutput({tag, ".multi"}, 32'(multi_press), 32'(multi));
  endtask

  int startCount;

  initial begin
    rst_n   = 1'b0;
    btn_raw = 8'hFF;
    enable  = 1'b0;

    // Reset held for 3 cycles with all buttons high.
    waitSample(3);
    checkEn = 1;
    checkOutput("reset.level", 32'(btn_level), 32'h0);
    checkEvent("reset", 8'h00, 1'b0, 3'd0, 1'b0);

    // Release reset: levels rise Db+1 edges after the first sample, no events.
    @(negedge clk);
    rst_n = 1'b1;
    waitSample(5);
    checkOutput("rstrel.level_early", 32'(btn_level), 32'h00);
    waitSample(1);
    checkOutput("rstrel.level", 32'(btn_level), 32'hFF);
    checkOutput("rstrel.press", 32'(btn_press), 32'h00);

    applyStimulus(8'h00, 1'b0);
    waitSample(10);
    checkOutput("release.level", 32'(btn_level), 32'h00);

    // Clean press on button 5.
    applyStimulus(8'h00, 1'b1);
    waitSample(2);
    applyStimulus(8'h20, 1'b1);
    waitSample(5);
    checkEvent("clean_pre", 8'h00, 1'b0, 3'd0, 1'b0);
    waitSample(1);
    checkEvent("clean", 8'h20, 1'b1, 3'd5, 1'b0);
    checkOutput("clean.level", 32'(btn_level), 32'h20);
    waitSample(1);
    checkEvent("clean_post", 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(8'h00, 1'b1);
    waitSample(10);

    // Bounce on button 2: 1,0,1,0 then held high.
    applyStimulus(8'h04, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h04, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h04, 1'b1);
    waitSample(5);
    checkEvent("bounce_pre", 8'h00, 1'b0, 3'd0, 1'b0);
    waitSample(1);
    checkEvent("bounce", 8'h04, 1'b1, 3'd2, 1'b0);
    applyStimulus(8'h00, 1'b1);
    waitSample(10);

    // Simultaneous presses on buttons 1 and 6.
    applyStimulus(8'h42, 1'b1);
    waitSample(6);
    checkEvent("simul", 8'h42, 1'b0, 3'd0, 1'b1);
    applyStimulus(8'h00, 1'b1);
    waitSample(10);

    // Enable gating: button 3 rises while disabled, no events ever.
    startCount = pressCount;
    applyStimulus(8'h08, 1'b0);
    waitSample(10);
    applyStimulus(8'h08, 1'b1);
    waitSample(8);
    checkOutput("gate.level", 32'(btn_level), 32'h08);
    checkOutput("gate.no_events", 32'(pressCount - startCount), 32'd0);
    applyStimulus(8'h00, 1'b1);
    waitSample(10);
    applyStimulus(8'h08, 1'b1);
    waitSample(6);
    checkEvent("gate_again", 8'h08, 1'b1, 3'd3, 1'b0);
    applyStimulus(8'h00, 1'b1);
    waitSample(10);

    // Hold button 0, then press button 4.
    applyStimulus(8'h01, 1'b1);
    waitSample(10);
    applyStimulus(8'h11, 1'b1);
    waitSample(6);
`ifdef BTN_LOCKOUT_EN
    checkEvent("roll", 8'h00, 1'b0, 3'd0, 1'b0);
`else
    checkEvent("roll", 8'h10, 1'b1, 3'd4, 1'b0);
`endif
    applyStimulus(8'h00, 1'b1);
    waitSample(10);
    applyStimulus(8'h10, 1'b1);
    waitSample(6);
    checkEvent("roll_after", 8'h10, 1'b1, 3'd4, 1'b0);
    applyStimulus(8'h00, 1'b1);
    waitSample(10);

    // Randomised run: bit flips at two rates, occasional enable toggles and
    // short resets, all checked against the model every cycle.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        for (int i = 0; i < NBtn; i++) begin
          if ($urandom_range(0, (phase == 0) ? 7 : 3) == 0) btn_raw[i] = ~btn_raw[i];
        end
        if ($urandom_range(0, 39) == 0) enable = ~enable;
        rst_n = ($urandom_range(0, 299) != 0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitSample(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
